// File: rtl/mmu_param_pkg.sv
// Shared types, IO region indices and wait-state lookup for the paged MMU.
package mmu_param_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } mmu_state_t;

    localparam int unsigned REG_VDC  = 0;
    localparam int unsigned REG_VCE  = 1;
    localparam int unsigned REG_PSG  = 2;
    localparam int unsigned REG_TMR  = 3;
    localparam int unsigned REG_IO   = 4;
    localparam int unsigned REG_IRQ  = 5;

    localparam int unsigned REGION_W = 3;
    localparam int unsigned IO_CE_W  = 8;
    localparam int unsigned WAIT_W   = 4;

    // Wait count for an IO region: nibble r of the packed wait vector.
    function automatic logic [WAIT_W-1:0] wait_of(input logic [REGION_W-1:0] region,
                                                  input logic [31:0] wait_vec);
        return wait_vec[{region, 2'b00} +: WAIT_W];
    endfunction

endpackage

// File: rtl/mmu_param_if.sv
// CPU-side bus of the MMU: paging requests, translation and chip-enable decode.
interface mmu_param_if
    import mmu_param_pkg::*;
#(
    parameter int unsigned VA_W      = 16,
    parameter int unsigned PAGE_BITS = 3,
    parameter int unsigned BANK_W    = 8
);
    localparam int unsigned NUM_MPR = 2 ** PAGE_BITS;
    localparam int unsigned PA_W    = BANK_W + VA_W - PAGE_BITS;

    logic               RE;
    logic               WE;
    logic               load_en;
    logic               store_en;
    logic [NUM_MPR-1:0] MPR_mask;
    logic [BANK_W-1:0]  d_in;
    logic [VA_W-1:0]    VADDR;
    logic               STx_override;
    logic [PA_W-1:0]    PADDR;
    logic [BANK_W-1:0]  d_out;
    logic               rom_ce_n;
    logic               ram_ce_n;
    logic [IO_CE_W-1:0] io_ce_n;
    logic               IO_sel;
    logic               MMU_stall;

    modport master (
        output RE, WE, load_en, store_en, MPR_mask, d_in, VADDR, STx_override,
        input  PADDR, d_out, rom_ce_n, ram_ce_n, io_ce_n, IO_sel, MMU_stall
    );

    modport slave (
        input  RE, WE, load_en, store_en, MPR_mask, d_in, VADDR, STx_override,
        output PADDR, d_out, rom_ce_n, ram_ce_n, io_ce_n, IO_sel, MMU_stall
    );

endinterface

// File: rtl/mmu_param_wait_gen.sv
// Programmable IO wait-state generator: n stall cycles, then one guaranteed free cycle.
module mmu_wait_gen
    import mmu_param_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rdy_i,
    input  logic              access_i,
    input  logic [WAIT_W-1:0] n_i,
    output logic              stall_o
);

    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              stall_q, stall_d;
    logic              hold_q, hold_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            stall_q <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            hold_q  <= hold_d;
        end
    end

    // hold_q marks the free cycle after a stall so a held access cannot re-arm at once.
    always_comb begin
        cnt_d   = cnt_q;
        stall_d = stall_q;
        hold_d  = hold_q;
        if (rdy_i) begin
            if (cnt_q != '0) begin
                cnt_d   = cnt_q - WAIT_W'(1);
                stall_d = (cnt_q != WAIT_W'(1));
                hold_d  = (cnt_q == WAIT_W'(1));
            end else if (hold_q) begin
                hold_d = 1'b0;
            end else if (access_i && !stall_q && (n_i != '0)) begin
                cnt_d   = n_i;
                stall_d = 1'b1;
            end
        end
    end

    assign stall_o = stall_q;

endmodule

// File: rtl/mmu_param.sv
// Paged MMU: MPR file with TAM/TMA sequencing, address translation and chip-enable decode.
module mmu_param
    import mmu_param_pkg::*;
#(
    parameter int unsigned       VA_W      = 16,
    parameter int unsigned       PAGE_BITS = 3,
    parameter int unsigned       BANK_W    = 8,
    parameter logic [BANK_W-1:0] IO_BANK   = BANK_W'(8'hFF),
    parameter logic [BANK_W-1:0] RAM_BANK  = BANK_W'(8'hF8),
    parameter int unsigned       RAM_BANKS = 1,
    parameter logic [31:0]       WAIT_VEC  = 32'h0000_0001
) (
    input logic        clk,
    input logic        reset,
    input logic        RDY,
    mmu_param_if.slave bus
);

    localparam int unsigned NUM_MPR = 2 ** PAGE_BITS;
    localparam int unsigned OFF_W   = VA_W - PAGE_BITS;
    localparam int unsigned PA_W    = BANK_W + OFF_W;
    localparam int unsigned RAM_LO  = 32'(RAM_BANK);

    mmu_state_t          state_q, state_d;
    logic [NUM_MPR-1:0]  mask_q, mask_d;
    logic [BANK_W-1:0]   databuf_q, databuf_d;
    logic [BANK_W-1:0]   mpr_q [NUM_MPR];
    logic [BANK_W-1:0]   mpr_d [NUM_MPR];

    logic [PAGE_BITS-1:0] page;
    logic [PAGE_BITS-1:0] low_idx;
    logic [PA_W-1:0]      paddr;
    logic [BANK_W-1:0]    bank;
    logic [REGION_W-1:0]  region;
    logic                 io_sel;
    logic                 ram_hit;
    logic [WAIT_W-1:0]    wait_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            databuf_q <= '0;
            for (int i = 0; i < int'(NUM_MPR); i++) mpr_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            databuf_q <= databuf_d;
            mpr_q     <= mpr_d;
        end
    end

    // TAM/TMA sequencer; nothing moves while RDY is low.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        databuf_d = databuf_q;
        for (int i = 0; i < int'(NUM_MPR); i++) mpr_d[i] = mpr_q[i];
        if (RDY) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.load_en) begin
                        mask_d = bus.MPR_mask;
                        if (bus.MPR_mask != '0) databuf_d = bus.d_in;
                        state_d = LOAD;
                    end else if (bus.store_en) begin
                        mask_d  = bus.MPR_mask;
                        state_d = STORE;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < int'(NUM_MPR); i++) begin
                        if (mask_q[i]) mpr_d[i] = databuf_q;
                    end
                    state_d = IDLE;
                end
                STORE:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = int'(NUM_MPR) - 1; i >= 0; i--) begin
            if (mask_q[i]) low_idx = PAGE_BITS'(i);
        end
    end

    assign bus.d_out = (state_q == STORE && mask_q != '0) ? mpr_q[low_idx] : databuf_q;

    // Translation and decode are combinational from the current (pre-LOAD) MPRs.
    assign page    = bus.VADDR[VA_W-1 -: PAGE_BITS];
    assign paddr   = bus.STx_override ? {IO_BANK, OFF_W'(bus.VADDR[1:0])}
                                      : {mpr_q[page], bus.VADDR[OFF_W-1:0]};
    assign bank    = paddr[PA_W-1 -: BANK_W];
    assign region  = paddr[OFF_W-1 -: REGION_W];
    assign io_sel  = (bank == IO_BANK);
    assign ram_hit = (32'(bank) >= RAM_LO) && (32'(bank) < RAM_LO + RAM_BANKS);

    assign bus.PADDR    = paddr;
    assign bus.IO_sel   = io_sel;
    assign bus.ram_ce_n = !ram_hit;
    assign bus.rom_ce_n = !((bank < IO_BANK) && !ram_hit);
    assign bus.io_ce_n  = io_sel ? ~(IO_CE_W'(1) << region) : '1;

    assign wait_n = wait_of(region, WAIT_VEC);

    mmu_wait_gen u_wait (
        .clk      (clk),
        .reset    (reset),
        .rdy_i    (RDY),
        .access_i ((bus.RE | bus.WE) & io_sel),
        .n_i      (wait_n),
        .stall_o  (bus.MMU_stall)
    );

endmodule

// File: tb/tb_mmu_param.sv
// Randomized self-checking bench for mmu_param against an arithmetic paging/wait model.
module tb_mmu_param;
    import mmu_param_pkg::*;

    localparam int unsigned VA_W      = 16;
    localparam int unsigned PAGE_BITS = 3;
    localparam int unsigned BANK_W    = 8;
    localparam int unsigned NUM_MPR   = 8;
    localparam int unsigned PA_W      = 21;
    localparam int unsigned PAGE_SZ   = 8192;
    localparam int unsigned IO_BANK   = 255;
    localparam int unsigned RAM_BANK  = 248;
    localparam int unsigned RAM_BANKS = 1;
    localparam logic [31:0] WAIT_A    = 32'h0000_0001;
    localparam logic [31:0] WAIT_B    = 32'h0000_0203;

    logic        clk = 1'b0;
    logic        reset;
    logic        rdy;
    logic        re, we, load_en, store_en, stx;
    logic [7:0]  mask, d_in;
    logic [15:0] vaddr;

    int unsigned mpr_m [NUM_MPR];
    int unsigned databuf_m;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mmu_param_if #(.VA_W(VA_W), .PAGE_BITS(PAGE_BITS), .BANK_W(BANK_W)) bus_a ();
    mmu_param_if #(.VA_W(VA_W), .PAGE_BITS(PAGE_BITS), .BANK_W(BANK_W)) bus_b ();

    assign bus_a.RE = re;           assign bus_b.RE = re;
    assign bus_a.WE = we;           assign bus_b.WE = we;
    assign bus_a.load_en = load_en; assign bus_b.load_en = load_en;
    assign bus_a.store_en = store_en; assign bus_b.store_en = store_en;
    assign bus_a.MPR_mask = mask;   assign bus_b.MPR_mask = mask;
    assign bus_a.d_in = d_in;       assign bus_b.d_in = d_in;
    assign bus_a.VADDR = vaddr;     assign bus_b.VADDR = vaddr;
    assign bus_a.STx_override = stx; assign bus_b.STx_override = stx;

    mmu_param #(.VA_W(VA_W), .PAGE_BITS(PAGE_BITS), .BANK_W(BANK_W), .IO_BANK(8'hFF),
                .RAM_BANK(8'hF8), .RAM_BANKS(RAM_BANKS), .WAIT_VEC(WAIT_A))
        dut_a (.clk(clk), .reset(reset), .RDY(rdy), .bus(bus_a));

    mmu_param #(.VA_W(VA_W), .PAGE_BITS(PAGE_BITS), .BANK_W(BANK_W), .IO_BANK(8'hFF),
                .RAM_BANK(8'hF8), .RAM_BANKS(RAM_BANKS), .WAIT_VEC(WAIT_B))
        dut_b (.clk(clk), .reset(reset), .RDY(rdy), .bus(bus_b));

    function automatic int unsigned exp_paddr(input int unsigned va, input bit ovr);
        if (ovr) return IO_BANK * PAGE_SZ + va % 4;
        return mpr_m[va / PAGE_SZ] * PAGE_SZ + va % PAGE_SZ;
    endfunction

    // {rom_ce_n, ram_ce_n, IO_sel, io_ce_n} for a physical address.
    function automatic logic [10:0] exp_ce(input int unsigned pa);
        int unsigned bank   = pa / PAGE_SZ;
        int unsigned region = (pa / 1024) % 8;
        logic [7:0]  io     = 8'hFF;
        logic        ram, rom, sel;
        sel = (bank == IO_BANK);
        ram = (bank >= RAM_BANK) && (bank < RAM_BANK + RAM_BANKS);
        rom = (bank < IO_BANK) && !ram;
        if (sel) io[region] = 1'b0;
        return {!rom, !ram, sel, io};
    endfunction

    // Held access: cycle 0 arms, cycles 1..n stall, cycle n+1 is free, then repeat.
    function automatic logic exp_stall(input int unsigned t, input int unsigned n);
        if (n == 0) return 1'b0;
        return ((t % (n + 2)) >= 1) && ((t % (n + 2)) <= n);
    endfunction

    function automatic logic [7:0] rand_bank();
        case ($urandom_range(0, 3))
            0:       return 8'hF8;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        re = 0; we = 0; load_en = 0; store_en = 0; stx = 0; rdy = 1;
        mask = '0; d_in = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(NUM_MPR); i++) mpr_m[i] = 0;
        databuf_m = 0;
    endtask

    task automatic tam(input logic [7:0] m, input logic [7:0] d);
        load_en = 1; mask = m; d_in = d;
        tick();
        load_en = 0; mask = '0; d_in = '0;
        @(negedge clk);
        checks++;
        if (bus_a.PADDR !== PA_W'(exp_paddr(vaddr, stx))) begin
            errors++;
            $display("FAIL load_old_mpr: PADDR=%h expected %h", bus_a.PADDR, PA_W'(exp_paddr(vaddr, stx)));
        end
        tick();
        if (m != 0) databuf_m = d;
        for (int i = 0; i < int'(NUM_MPR); i++) if (m[i]) mpr_m[i] = d;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; vaddr = 16'hE123;
        tick(); tick();
        reset = 0;
        clear_model();
        @(negedge clk);
        checks++;
        if (bus_a.PADDR !== 21'h000123) begin errors++; $display("FAIL reset_paddr: %h expected 000123", bus_a.PADDR); end
        checks++;
        if (bus_a.rom_ce_n !== 1'b0) begin errors++; $display("FAIL reset_rom_ce: %b expected 0", bus_a.rom_ce_n); end
        checks++;
        if ({bus_a.MMU_stall, bus_b.MMU_stall} !== 2'b00) begin
            errors++; $display("FAIL reset_stall: %b expected 00", {bus_a.MMU_stall, bus_b.MMU_stall});
        end
        checks++;
        if (bus_a.d_out !== 8'h00) begin errors++; $display("FAIL reset_dout: %h expected 00", bus_a.d_out); end
        tick();
    endtask

    task automatic test_tam_translate();
        vaddr = 16'h0010;
        tam(8'h81, 8'hF8);
        @(negedge clk);
        checks++;
        if (bus_a.PADDR !== 21'h1F0010) begin errors++; $display("FAIL tam_paddr0: %h expected 1F0010", bus_a.PADDR); end
        checks++;
        if ({bus_a.ram_ce_n, bus_a.rom_ce_n} !== 2'b01) begin
            errors++; $display("FAIL tam_ram_ce: ram/rom=%b expected 01", {bus_a.ram_ce_n, bus_a.rom_ce_n});
        end
        vaddr = 16'hE010;
        #1;
        checks++;
        if (bus_a.PADDR !== 21'h1F0010) begin errors++; $display("FAIL tam_paddr7: %h expected 1F0010", bus_a.PADDR); end
        tick();
        repeat (16) begin
            vaddr = 16'($urandom);
            tam(8'($urandom), rand_bank());
        end
        repeat (32) begin
            vaddr = 16'($urandom);
            @(negedge clk);
            checks++;
            if (bus_a.PADDR !== PA_W'(exp_paddr(vaddr, 0))) begin
                errors++; $display("FAIL rand_paddr: va=%h PADDR=%h expected %h", vaddr, bus_a.PADDR, PA_W'(exp_paddr(vaddr, 0)));
            end
            checks++;
            if ({bus_a.rom_ce_n, bus_a.ram_ce_n, bus_a.IO_sel, bus_a.io_ce_n} !== exp_ce(exp_paddr(vaddr, 0))) begin
                errors++; $display("FAIL rand_ce: va=%h ce=%h expected %h", vaddr,
                    {bus_a.rom_ce_n, bus_a.ram_ce_n, bus_a.IO_sel, bus_a.io_ce_n}, exp_ce(exp_paddr(vaddr, 0)));
            end
            tick();
        end
    endtask

    task automatic test_tma();
        logic [7:0]  m;
        int unsigned lo;
        int unsigned expv;
        tam(8'h02, 8'h11);
        tam(8'h04, 8'h22);
        for (int k = 0; k < 12; k++) begin
            m = (k == 0) ? 8'h06 : (k == 1) ? 8'h00 : 8'($urandom);
            lo = 0;
            for (int i = 7; i >= 0; i--) if (m[i]) lo = i;
            expv = (m == 0) ? databuf_m : mpr_m[lo];
            store_en = 1; mask = m;
            tick();
            store_en = 0; mask = '0;
            @(negedge clk);
            checks++;
            if (bus_a.d_out !== 8'(expv)) begin
                errors++; $display("FAIL tma_dout: mask=%h d_out=%h expected %h", m, bus_a.d_out, 8'(expv));
            end
            tick();
            @(negedge clk);
            checks++;
            if (bus_a.d_out !== 8'(databuf_m)) begin
                errors++; $display("FAIL tma_after: d_out=%h expected %h", bus_a.d_out, 8'(databuf_m));
            end
            tick();
        end
    endtask

    task automatic test_load_store_same();
        tam(8'h10, 8'h33);
        load_en = 1; store_en = 1; mask = 8'h10; d_in = 8'h5A;
        tick();
        load_en = 0; store_en = 0; mask = '0; d_in = '0;
        @(negedge clk);
        checks++;
        if (bus_a.d_out !== 8'h5A) begin errors++; $display("FAIL both_dout: %h expected 5A", bus_a.d_out); end
        tick();
        databuf_m = 8'h5A; mpr_m[4] = 8'h5A;
        vaddr = 16'h8000 + 16'($urandom_range(0, 8191));
        @(negedge clk);
        checks++;
        if (bus_a.PADDR !== PA_W'(exp_paddr(vaddr, 0))) begin
            errors++; $display("FAIL both_paddr: %h expected %h", bus_a.PADDR, PA_W'(exp_paddr(vaddr, 0)));
        end
        tick();
    endtask

    task automatic test_reset_mid_load();
        reset = 1; tick(); reset = 0;
        clear_model();
        load_en = 1; mask = 8'hFF; d_in = 8'h77;
        tick();
        load_en = 0; mask = '0; d_in = '0; reset = 1;
        tick();
        reset = 0;
        for (int p = 0; p < int'(NUM_MPR); p++) begin
            vaddr = 16'(p * PAGE_SZ + $urandom_range(0, PAGE_SZ - 1));
            @(negedge clk);
            checks++;
            if (bus_a.PADDR !== PA_W'(vaddr % PAGE_SZ)) begin
                errors++; $display("FAIL rst_load_paddr: page %0d PADDR=%h expected %h", p, bus_a.PADDR, PA_W'(vaddr % PAGE_SZ));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus_a.d_out !== 8'h00) begin errors++; $display("FAIL rst_load_dout: %h expected 00", bus_a.d_out); end
        tick();
    endtask

    task automatic test_override();
        repeat (4) tam(8'($urandom), rand_bank());
        stx = 1; vaddr = 16'h0003;
        @(negedge clk);
        checks++;
        if (bus_a.PADDR !== 21'h1FE003) begin errors++; $display("FAIL stx_paddr: %h expected 1FE003", bus_a.PADDR); end
        checks++;
        if ({bus_a.rom_ce_n, bus_a.ram_ce_n, bus_a.IO_sel, bus_a.io_ce_n} !== 11'b1_1_1_11111110) begin
            errors++; $display("FAIL stx_ce: %b expected 11111111110",
                {bus_a.rom_ce_n, bus_a.ram_ce_n, bus_a.IO_sel, bus_a.io_ce_n});
        end
        tick();
        repeat (6) begin
            vaddr = 16'($urandom);
            @(negedge clk);
            checks++;
            if (bus_b.PADDR !== PA_W'(exp_paddr(vaddr, 1))) begin
                errors++; $display("FAIL stx_rand: va=%h PADDR=%h expected %h", vaddr, bus_b.PADDR, PA_W'(exp_paddr(vaddr, 1)));
            end
            tick();
        end
        stx = 0;
    endtask

    task automatic test_io_decode();
        int unsigned regs [6] = '{REG_VDC, REG_VCE, REG_PSG, REG_TMR, REG_IO, REG_IRQ};
        tam(8'h20, 8'hFF);
        foreach (regs[k]) begin
            vaddr = 16'(16'hA000 + regs[k] * 1024 + $urandom_range(0, 1023));
            @(negedge clk);
            checks++;
            if ({bus_a.rom_ce_n, bus_a.ram_ce_n, bus_a.IO_sel, bus_a.io_ce_n} !== exp_ce(exp_paddr(vaddr, 0))) begin
                errors++; $display("FAIL io_region%0d: ce=%h expected %h", regs[k],
                    {bus_a.rom_ce_n, bus_a.ram_ce_n, bus_a.IO_sel, bus_a.io_ce_n}, exp_ce(exp_paddr(vaddr, 0)));
            end
            tick();
        end
    endtask

    task automatic test_wait_states();
        logic [15:0] addrs [4] = '{16'h0000, 16'h0400, 16'h0800, 16'h0C05};
        tam(8'h01, 8'hFF);
        foreach (addrs[k]) begin
            int unsigned r  = (addrs[k] / 1024) % 8;
            int unsigned na = (WAIT_A >> (4 * r)) & 32'hF;
            int unsigned nb = (WAIT_B >> (4 * r)) & 32'hF;
            int unsigned t  = 0;
            vaddr = addrs[k];
            re = (k % 2 == 0); we = (k % 2 != 0);
            for (int c = 0; c < 16; c++) begin
                rdy = (c < 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
                @(negedge clk);
                checks++;
                if (bus_a.MMU_stall !== exp_stall(t, na)) begin
                    errors++; $display("FAIL stall_a: region %0d cycle %0d got %b expected %b", r, c, bus_a.MMU_stall, exp_stall(t, na));
                end
                checks++;
                if (bus_b.MMU_stall !== exp_stall(t, nb)) begin
                    errors++; $display("FAIL stall_b: region %0d cycle %0d got %b expected %b", r, c, bus_b.MMU_stall, exp_stall(t, nb));
                end
                if (rdy) t++;
                tick();
            end
            re = 0; we = 0; rdy = 1;
            repeat (6) tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        vaddr = 16'h0000; re = 1; rdy = 1;
        tick();
        @(negedge clk);
        checks++;
        if (bus_b.MMU_stall !== 1'b1) begin errors++; $display("FAIL stall_armed: %b expected 1", bus_b.MMU_stall); end
        reset = 1;
        tick();
        reset = 0; re = 0;
        clear_model();
        @(negedge clk);
        checks++;
        if ({bus_a.MMU_stall, bus_b.MMU_stall} !== 2'b00) begin
            errors++; $display("FAIL rst_stall: %b expected 00", {bus_a.MMU_stall, bus_b.MMU_stall});
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        vaddr = '0;
        test_reset();
        test_tam_translate();
        test_tma();
        test_load_store_same();
        test_reset_mid_load();
        test_override();
        test_io_decode();
        test_wait_states();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
